// File: rtl/driver_motoare_pwm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// driver_motoare_pwm_if : motion-logic <-> H-bridge driver signal bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface driver_motoare_pwm_if;
    logic [1:0]  directie_driverA;
    logic [1:0]  directie_driverB;
    logic [11:0] factor_dc_driverA;
    logic [11:0] factor_dc_driverB;
    logic [1:0]  in_driverA;
    logic [1:0]  in_driverB;
    logic        en_driverA;
    logic        en_driverB;
    logic        mort_A;
    logic        mort_B;
    logic        inceput_perioada;

    modport master (
        output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        input  in_driverA, in_driverB, en_driverA, en_driverB, mort_A, mort_B, inceput_perioada
    );

    modport slave (
        input  directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        output in_driverA, in_driverB, en_driverA, en_driverB, mort_A, mort_B, inceput_perioada
    );
endinterface
`default_nettype wire

// File: rtl/driver_motoare_pwm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// driver_motoare_pwm : two-channel H-bridge driver, BCD PWM with reversal dead-time
// Revision 1.0
// ---------------------------------------------------------------------------
module driver_motoare_pwm #(
    parameter int PRESCALE    = 50,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    driver_motoare_pwm_if.slave  bus
);
    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int              DW         = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]   DEAD_LOAD  = DW'(DEAD_CYCLES - 1);
    localparam logic [11:0]     BCD_MAX    = 12'h999;

    typedef enum logic [0:0] {RUN = 1'b0, DEAD = 1'b1} state_t;

    logic [PW-1:0] presc;
    logic [11:0]   bcd_cnt;
    logic [11:0]   bcd_next;
    logic          tick;
    logic          wrap;
    logic          period_start;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (bcd_cnt == BCD_MAX);

    always_comb begin
        bcd_next = bcd_cnt;
        if (bcd_cnt[3:0] != 4'd9) begin
            bcd_next[3:0] = bcd_cnt[3:0] + 4'd1;
        end else begin
            bcd_next[3:0] = 4'd0;
            if (bcd_cnt[7:4] != 4'd9) begin
                bcd_next[7:4] = bcd_cnt[7:4] + 4'd1;
            end else begin
                bcd_next[7:4]  = 4'd0;
                bcd_next[11:8] = (bcd_cnt[11:8] == 4'd9) ? 4'd0 : bcd_cnt[11:8] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            bcd_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (tick) begin
                presc   <= '0;
                bcd_cnt <= bcd_next;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign bus.inceput_perioada = period_start;

    logic [1:0]  dir_in   [2];
    logic [11:0] duty_in  [2];
    logic [1:0]  dir_out  [2];
    logic        en_out   [2];
    logic        mort_out [2];

    assign dir_in[0]      = bus.directie_driverA;
    assign dir_in[1]      = bus.directie_driverB;
    assign duty_in[0]     = bus.factor_dc_driverA;
    assign duty_in[1]     = bus.factor_dc_driverB;
    assign bus.in_driverA = dir_out[0];
    assign bus.in_driverB = dir_out[1];
    assign bus.en_driverA = en_out[0];
    assign bus.en_driverB = en_out[1];
    assign bus.mort_A     = mort_out[0];
    assign bus.mort_B     = mort_out[1];

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            state_t        state;
            logic [1:0]    dir;
            logic [DW-1:0] dead_cnt;
            logic [11:0]   shadow;
            logic [11:0]   duty_ok;
            logic          bad_digit;
            logic          pwm;

            // Counter and shadow are always valid BCD, so a plain binary compare orders them digit-wise.
            assign bad_digit = (duty_in[ch][11:8] > 4'd9) || (duty_in[ch][7:4] > 4'd9) ||
                               (duty_in[ch][3:0] > 4'd9);
            assign duty_ok   = bad_digit ? BCD_MAX : duty_in[ch];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    shadow <= '0;
                    pwm    <= 1'b0;
                end else begin
                    if (wrap) begin
                        shadow <= duty_ok;
                    end
                    pwm <= (bcd_cnt < shadow);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state    <= RUN;
                    dir      <= 2'b00;
                    dead_cnt <= '0;
                end else begin
                    case (state)
                        RUN: begin
                            if (dir_in[ch] != dir) begin
                                if (dir_in[ch] == 2'b00 || dir == 2'b00) begin
                                    dir <= dir_in[ch];
                                end else begin
                                    state    <= DEAD;
                                    dir      <= 2'b00;
                                    dead_cnt <= DEAD_LOAD;
                                end
                            end
                        end
                        DEAD: begin
                            if (dir_in[ch] == 2'b00) begin
                                state <= RUN;
                                dir   <= 2'b00;
                            end else if (dead_cnt == '0) begin
                                state <= RUN;
                                dir   <= dir_in[ch];
                            end else begin
                                dead_cnt <= dead_cnt - 1'b1;
                            end
                        end
                        default: state <= RUN;
                    endcase
                end
            end

            assign dir_out[ch]  = dir;
            assign mort_out[ch] = (state == DEAD);
            assign en_out[ch]   = (state == DEAD || dir == 2'b00) ? 1'b0 :
                                  (dir == 2'b11) ? 1'b1 : pwm;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_driver_motoare_pwm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_driver_motoare_pwm : randomized self-checking bench for driver_motoare_pwm
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_driver_motoare_pwm;
    localparam int DEAD = 4;

    logic clk = 1'b0;
    logic reset;

    driver_motoare_pwm_if bus ();

    driver_motoare_pwm #(.PRESCALE(1), .DEAD_CYCLES(DEAD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: PWM position 0..999, applied duty per period, dead-time clocks left.
    int m_cnt, m_start;
    int m_shadow [2];
    int m_pwm    [2];
    int m_dir    [2];
    int m_dead   [2];

    function automatic int duty_value(input logic [11:0] d);
        if (d[11:8] > 4'd9 || d[7:4] > 4'd9 || d[3:0] > 4'd9) return 999;
        return int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [1:0] in_dir(input int c);
        return (c == 0) ? bus.directie_driverA : bus.directie_driverB;
    endfunction

    function automatic logic [11:0] in_duty(input int c);
        return (c == 0) ? bus.factor_dc_driverA : bus.factor_dc_driverB;
    endfunction

    function automatic logic [1:0] dut_in(input int c);
        return (c == 0) ? bus.in_driverA : bus.in_driverB;
    endfunction

    function automatic logic dut_en(input int c);
        return (c == 0) ? bus.en_driverA : bus.en_driverB;
    endfunction

    function automatic logic dut_mort(input int c);
        return (c == 0) ? bus.mort_A : bus.mort_B;
    endfunction

    function automatic int m_en(input int c);
        if (m_dead[c] > 0 || m_dir[c] == 0) return 0;
        if (m_dir[c] == 3) return 1;
        return m_pwm[c];
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_start = 0;
        for (int c = 0; c < 2; c++) begin
            m_shadow[c] = 0; m_pwm[c] = 0; m_dir[c] = 0; m_dead[c] = 0;
        end
    endtask

    task automatic model_clock();
        int nd;
        for (int c = 0; c < 2; c++) m_pwm[c] = (m_cnt < m_shadow[c]) ? 1 : 0;
        if (m_cnt == 999) begin
            m_cnt   = 0;
            m_start = 1;
            for (int c = 0; c < 2; c++) m_shadow[c] = duty_value(in_duty(c));
        end else begin
            m_cnt   = m_cnt + 1;
            m_start = 0;
        end
        for (int c = 0; c < 2; c++) begin
            nd = int'(in_dir(c));
            if (m_dead[c] > 0) begin
                if (nd == 0) begin
                    m_dir[c] = 0; m_dead[c] = 0;
                end else if (m_dead[c] == 1) begin
                    m_dir[c] = nd; m_dead[c] = 0;
                end else begin
                    m_dead[c] = m_dead[c] - 1;
                end
            end else if (nd != m_dir[c]) begin
                if (nd == 0 || m_dir[c] == 0) m_dir[c] = nd;
                else begin
                    m_dir[c] = 0; m_dead[c] = DEAD;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_clock();
        @(negedge clk);
    endtask

    task automatic run_window(input logic [11:0] next_a, input logic [11:0] next_b,
                              input int change_at, output int hi_a, output int hi_b,
                              output int starts, output int start_pos);
        hi_a = 0; hi_b = 0; starts = 0; start_pos = -1;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (bus.en_driverA === 1'b1) hi_a++;
            if (bus.en_driverB === 1'b1) hi_b++;
            if (bus.inceput_perioada === 1'b1) begin
                starts++;
                start_pos = i;
            end
            if (i == change_at) begin
                bus.factor_dc_driverA = next_a;
                bus.factor_dc_driverB = next_b;
            end
        end
    endtask

    task automatic test_reset();
        bus.directie_driverA  = 2'b10;
        bus.directie_driverB  = 2'b11;
        bus.factor_dc_driverA = 12'h999;
        bus.factor_dc_driverB = 12'h999;
        repeat (3) step();
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (dut_in(c) !== 2'b00) $display("FAIL reset_in ch%0d got %b want 00", c, dut_in(c));
            else n_pass++;
            n_checks++;
            if (dut_en(c) !== 1'b0) $display("FAIL reset_en ch%0d got %b want 0", c, dut_en(c));
            else n_pass++;
            n_checks++;
            if (dut_mort(c) !== 1'b0) $display("FAIL reset_mort ch%0d got %b want 0", c, dut_mort(c));
            else n_pass++;
        end
        n_checks++;
        if (bus.inceput_perioada !== 1'b0) $display("FAIL reset_start got %b want 0", bus.inceput_perioada);
        else n_pass++;
    endtask

    task automatic first_period(input string tag);
        int hi0, wrap_at;
        hi0 = 0; wrap_at = -1;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (bus.en_driverA === 1'b1) hi0++;
            if (bus.inceput_perioada === 1'b1) begin
                wrap_at = i;
                break;
            end
        end
        n_checks++;
        if (wrap_at != 1000) $display("FAIL %s first_wrap got %0d want 1000", tag, wrap_at);
        else n_pass++;
        n_checks++;
        if (hi0 != 0) $display("FAIL %s first_period_en got %0d want 0", tag, hi0);
        else n_pass++;
    endtask

    task automatic test_pwm_period();
        int ha, hb, st, sp;
        logic [11:0] db;
        db = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
        reset = 1'b0;
        bus.directie_driverA  = 2'b10;
        bus.directie_driverB  = 2'b10;
        bus.factor_dc_driverA = 12'h500;
        bus.factor_dc_driverB = db;
        first_period("pwm");
        run_window(12'h500, db, 0, ha, hb, st, sp);
        n_checks++;
        if (ha != 500) $display("FAIL pwm500_high got %0d want 500", ha);
        else n_pass++;
        n_checks++;
        if (hb != duty_value(db)) $display("FAIL pwm_b_high duty %h got %0d want %0d", db, hb, duty_value(db));
        else n_pass++;
        n_checks++;
        if (st != 1 || sp != 1000) $display("FAIL pwm_start count %0d pos %0d want 1 at 1000", st, sp);
        else n_pass++;
    endtask

    task automatic test_duty_update();
        logic [11:0] next_a [8];
        int          chg    [8];
        logic [11:0] cur_a, cur_b, nb;
        int ha, hb, st, sp;
        next_a[0] = 12'h250; chg[0] = 1;
        next_a[1] = 12'h750; chg[1] = 300;
        next_a[2] = 12'h9A0; chg[2] = 500;
        next_a[3] = 12'h000; chg[3] = 10;
        for (int k = 4; k < 8; k++) begin
            next_a[k] = 12'($urandom_range(4095));
            chg[k]    = $urandom_range(999, 1);
        end
        cur_a = bus.factor_dc_driverA;
        cur_b = bus.factor_dc_driverB;
        for (int k = 0; k < 8; k++) begin
            nb = 12'($urandom_range(4095));
            run_window(next_a[k], nb, chg[k], ha, hb, st, sp);
            n_checks++;
            if (ha != duty_value(cur_a)) $display("FAIL duty_a w%0d duty %h got %0d want %0d", k, cur_a, ha, duty_value(cur_a));
            else n_pass++;
            n_checks++;
            if (hb != duty_value(cur_b)) $display("FAIL duty_b w%0d duty %h got %0d want %0d", k, cur_b, hb, duty_value(cur_b));
            else n_pass++;
            n_checks++;
            if (st != 1 || sp != 1000) $display("FAIL duty_start w%0d count %0d pos %0d want 1 at 1000", k, st, sp);
            else n_pass++;
            cur_a = next_a[k];
            cur_b = nb;
        end
        bus.factor_dc_driverA = 12'h500;
        bus.factor_dc_driverB = 12'h500;
    endtask

    task automatic check_a(input string tag, input int i, input logic [1:0] want_in, input logic want_mort);
        // Only used for channel A sequences; B must stay at 10 throughout.
        n_checks++;
        if (bus.in_driverA !== want_in || bus.mort_A !== want_mort || (want_mort && bus.en_driverA !== 1'b0))
            $display("FAIL %s clk%0d in_A %b mort_A %b en_A %b want in %b mort %b", tag, i,
                     bus.in_driverA, bus.mort_A, bus.en_driverA, want_in, want_mort);
        else n_pass++;
        n_checks++;
        if (bus.in_driverB !== 2'b10 || bus.mort_B !== 1'b0)
            $display("FAIL %s clk%0d in_B %b mort_B %b want 10/0", tag, i, bus.in_driverB, bus.mort_B);
        else n_pass++;
    endtask

    task automatic test_reversal();
        bus.directie_driverA = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_a("reversal", i, (i <= DEAD) ? 2'b00 : 2'b01, (i <= DEAD));
        end
    endtask

    task automatic test_dead_change();
        bus.directie_driverA = 2'b00; step(); check_a("to_coast", 0, 2'b00, 1'b0);
        bus.directie_driverA = 2'b10; step(); check_a("to_fwd", 0, 2'b10, 1'b0);
        bus.directie_driverA = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_a("dead_change", i, (i <= DEAD) ? 2'b00 : 2'b10, (i <= DEAD));
            if (i == 2) bus.directie_driverA = 2'b10;
        end
        bus.directie_driverA = 2'b01;
        step(); check_a("abort", 1, 2'b00, 1'b1);
        step(); check_a("abort", 2, 2'b00, 1'b1);
        bus.directie_driverA = 2'b00;
        step(); check_a("abort", 3, 2'b00, 1'b0);
    endtask

    task automatic test_coast_path();
        int lows;
        bus.directie_driverA = 2'b10; step(); check_a("coast_path", 1, 2'b10, 1'b0);
        bus.directie_driverA = 2'b00; step(); check_a("coast_path", 2, 2'b00, 1'b0);
        bus.directie_driverA = 2'b01; step(); check_a("coast_path", 3, 2'b01, 1'b0);
        bus.directie_driverA = 2'b00; step(); check_a("coast_path", 4, 2'b00, 1'b0);
        bus.directie_driverA = 2'b11; step(); check_a("brake", 1, 2'b11, 1'b0);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.en_driverA !== 1'b1) lows++;
            step();
        end
        n_checks++;
        if (lows != 0) $display("FAIL brake_en low_cycles got %0d want 0", lows);
        else n_pass++;
    endtask

    task automatic test_random_dirs();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) bus.directie_driverA = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) bus.directie_driverB = 2'($urandom_range(3));
            if ($urandom_range(63) == 0) bus.factor_dc_driverA = 12'($urandom_range(4095));
            if ($urandom_range(63) == 0) bus.factor_dc_driverB = 12'($urandom_range(4095));
            step();
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (dut_in(c) !== 2'(m_dir[c]) || dut_mort(c) !== (m_dead[c] > 0) || dut_en(c) !== 1'(m_en(c)))
                    $display("FAIL rand_ch%0d cyc%0d in %b mort %b en %b want in %0d mort %0d en %0d", c, i,
                             dut_in(c), dut_mort(c), dut_en(c), m_dir[c], (m_dead[c] > 0), m_en(c));
                else n_pass++;
            end
            n_checks++;
            if (bus.inceput_perioada !== 1'(m_start))
                $display("FAIL rand_start cyc%0d got %b want %0d", i, bus.inceput_perioada, m_start);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int ha, hb, st, sp;
        bus.directie_driverB = 2'b11;
        bus.directie_driverA = 2'b00; step();
        bus.directie_driverA = 2'b10; step();
        bus.directie_driverA = 2'b01; step();
        n_checks++;
        if (bus.mort_A !== 1'b1 || bus.en_driverB !== 1'b1)
            $display("FAIL pre_reset mort_A %b en_B %b want 1/1", bus.mort_A, bus.en_driverB);
        else n_pass++;
        @(posedge clk);
        model_clock();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({bus.in_driverA, bus.in_driverB, bus.en_driverA, bus.en_driverB,
             bus.mort_A, bus.mort_B, bus.inceput_perioada} !== 9'b0)
            $display("FAIL async_reset outputs got %b want 0", {bus.in_driverA, bus.in_driverB,
                     bus.en_driverA, bus.en_driverB, bus.mort_A, bus.mort_B, bus.inceput_perioada});
        else n_pass++;
        @(negedge clk);
        step();
        bus.directie_driverA  = 2'b10;
        bus.directie_driverB  = 2'b10;
        bus.factor_dc_driverA = 12'h999;
        bus.factor_dc_driverB = 12'h999;
        reset = 1'b0;
        first_period("after_reset");
        run_window(12'h999, 12'h999, 0, ha, hb, st, sp);
        n_checks++;
        if (ha != 999 || hb != 999) $display("FAIL after_reset_high got %0d/%0d want 999/999", ha, hb);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        test_reset();
        test_pwm_period();
        test_duty_update();
        test_reversal();
        test_dead_change();
        test_coast_path();
        test_random_dirs();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
